// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file and write strobe.
// Pointer byte selects the register; reads and writes auto-increment it.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int NREG = 8,
  parameter int FILT_LEN = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    scl_i,
  output logic                    scl_o,
  output logic                    scl_t,
  input  logic                    sda_i,
  output logic                    sda_o,
  output logic                    sda_t,
  output logic [NREG*8-1:0]       regs,
  output logic                    wr_stb,
  output logic [$clog2(NREG)-1:0] wr_idx,
  output logic                    busy
);

  localparam int PW = $clog2(NREG);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] FMAX = CW'(FILT_LEN - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_AACK = 4'd2;
  localparam logic [3:0] S_PTR  = 4'd3;
  localparam logic [3:0] S_PACK = 4'd4;
  localparam logic [3:0] S_WDAT = 4'd5;
  localparam logic [3:0] S_WACK = 4'd6;
  localparam logic [3:0] S_RDAT = 4'd7;
  localparam logic [3:0] S_MACK = 4'd8;
  localparam logic [3:0] S_IGN  = 4'd9;

  // bit 0 = scl, bit 1 = sda
  logic [1:0]      r_s1;
  logic [1:0]      r_s2;
  logic [1:0]      r_f;
  logic [1:0]      r_fd;
  logic [CW-1:0]   r_fcnt [2];

  logic [3:0]      r_state;
  logic [3:0]      r_bcnt;
  logic [7:0]      r_shift;
  logic            r_rw;
  logic [PW-1:0]   r_ptr;
  logic [NREG*8-1:0] r_regs;
  logic            r_sda_t;
  logic            r_stb;
  logic [PW-1:0]   r_idx;
  logic            r_busy;

  logic            w_sda_f;
  logic            w_rise;
  logic            w_fall;
  logic            w_start;
  logic            w_stop;
  logic            w_bit8;
  logic            w_shifting;
  logic [7:0]      w_rd;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_s1      <= 2'b11;
      r_s2      <= 2'b11;
      r_f       <= 2'b11;
      r_fd      <= 2'b11;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      r_s1 <= {sda_i, scl_i};
      r_s2 <= r_s1;
      r_fd <= r_f;
      for (int k = 0; k < 2; k++) begin
        if (r_s2[k] == r_f[k]) begin
          r_fcnt[k] <= '0;
        end else if (r_fcnt[k] == FMAX) begin
          r_f[k]    <= r_s2[k];
          r_fcnt[k] <= '0;
        end else begin
          r_fcnt[k] <= r_fcnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_sda_f    = r_f[1];
  assign w_rise     = r_f[0] & ~r_fd[0];
  assign w_fall     = ~r_f[0] & r_fd[0];
  assign w_start    = r_fd[1] & ~r_f[1] & r_f[0];
  assign w_stop     = ~r_fd[1] & r_f[1] & r_f[0];
  assign w_bit8     = (r_bcnt == 4'd8);
  assign w_shifting = (r_state == S_ADDR) || (r_state == S_PTR) ||
                      (r_state == S_WDAT);
  assign w_rd       = r_regs[{r_ptr, 3'b000} +: 8];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_rw    <= 1'b0;
      r_ptr   <= '0;
      r_regs  <= '0;
      r_sda_t <= 1'b1;
      r_stb   <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_stop) begin
        r_state <= S_IDLE;
        r_sda_t <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state <= S_ADDR;
        r_bcnt  <= '0;
        r_sda_t <= 1'b1;
      end else begin
        if (w_shifting && w_rise && !w_bit8) begin
          r_shift <= {r_shift[6:0], w_sda_f};
          r_bcnt  <= r_bcnt + 1'b1;
        end
        case (r_state)
          S_ADDR: if (w_fall && w_bit8) begin
            r_bcnt <= '0;
            if (r_shift[7:1] == I2C_ADDR) begin
              r_state <= S_AACK;
              r_sda_t <= 1'b0;
              r_busy  <= 1'b1;
              r_rw    <= r_shift[0];
            end else begin
              r_state <= S_IGN;
            end
          end
          S_AACK: if (w_fall) begin
            if (r_rw) begin
              r_sda_t <= w_rd[7];
              r_shift <= {w_rd[6:0], 1'b0};
              r_bcnt  <= 4'd1;
              r_ptr   <= r_ptr + 1'b1;
              r_state <= S_RDAT;
            end else begin
              r_sda_t <= 1'b1;
              r_state <= S_PTR;
            end
          end
          S_PTR: if (w_fall && w_bit8) begin
            r_bcnt  <= '0;
            r_ptr   <= r_shift[PW-1:0];
            r_sda_t <= 1'b0;
            r_state <= S_PACK;
          end
          S_WDAT: if (w_fall && w_bit8) begin
            r_bcnt <= '0;
            r_regs[{r_ptr, 3'b000} +: 8] <= r_shift;
            r_stb   <= 1'b1;
            r_idx   <= r_ptr;
            r_ptr   <= r_ptr + 1'b1;
            r_sda_t <= 1'b0;
            r_state <= S_WACK;
          end
          S_PACK, S_WACK: if (w_fall) begin
            r_sda_t <= 1'b1;
            r_state <= S_WDAT;
          end
          S_RDAT: if (w_fall) begin
            if (w_bit8) begin
              r_sda_t <= 1'b1;
              r_state <= S_MACK;
            end else begin
              r_sda_t <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
              r_bcnt  <= r_bcnt + 1'b1;
            end
          end
          S_MACK: begin
            if (w_rise && w_sda_f) begin
              r_state <= S_IGN;
            end else if (w_fall) begin
              r_sda_t <= w_rd[7];
              r_shift <= {w_rd[6:0], 1'b0};
              r_bcnt  <= 4'd1;
              r_ptr   <= r_ptr + 1'b1;
              r_state <= S_RDAT;
            end
          end
          S_IGN: r_sda_t <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign scl_o  = 1'b0;
  assign scl_t  = 1'b1;
  assign sda_o  = 1'b0;
  assign sda_t  = r_sda_t;
  assign regs   = r_regs;
  assign wr_stb = r_stb;
  assign wr_idx = r_idx;
  assign busy   = r_busy;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (slave) responder with an internal byte-wide register file. It answers a fixed 7-bit address on the same scl/sda IOBUF tristate triplets that the on-chip AXI I2C initiator drives. The FPGA can therefore be addressed by an external or loopback I2C master. Register contents go to fabric logic, and every write produces a strobe.

Parameters:
I2C_ADDR, 7'h42, 7-bit target address matched after START.
NREG, 8, number of 8-bit registers; power of two, 2..256.
FILT_LEN, 4, consecutive identical synchronized samples needed before a filtered SCL/SDA level changes.

Ports:
axi_aclk  in  1  system clock; must be >= 20x SCL rate (100 MHz nominal, SCL <= 400 kHz).
axi_aresetn  in  1  asynchronous active-low reset.
scl_i  in  1  SCL from IOBUF.
scl_o  out  1  SCL drive value; constant 0.
scl_t  out  1  SCL tristate, 1 = released; constant 1 (no clock stretching).
sda_i  in  1  SDA from IOBUF.
sda_o  out  1  SDA drive value; constant 0.
sda_t  out  1  SDA tristate; 0 = pull low, 1 = release.
regs  out  NREG*8  register file; regs[8*i+7:8*i] is register i.
wr_stb  out  1  one-cycle pulse when a register is written.
wr_idx  out  $clog2(NREG)  index written; valid with wr_stb.
busy  out  1  high from address match until STOP.

Behaviour:
- Reset (async assert, sync release): sda_t=1, regs=0, wr_stb=0, wr_idx=0, busy=0, pointer=0, state=IDLE.
- Input conditioning: scl_i and sda_i each pass through a 2-flop synchronizer, then a FILT_LEN glitch filter, giving scl_f and sda_f.
- Edge and condition detection:
  - SCL rise = scl_f 0->1; SCL fall = scl_f 1->0.
  - START = sda_f 1->0 while scl_f=1.
  - STOP = sda_f 0->1 while scl_f=1.
- Bit handling: data bits are sampled on SCL rise, MSB first. SDA is only changed on SCL fall, one cycle after the filtered edge.
- STOP, from any state: go to IDLE, sda_t=1, busy=0. The pointer is retained.
- START, from any state including mid-byte (repeated START): go to ADDR, clear the bit counter, sda_t=1. The pointer is retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the SCL fall after bit 8: if addr[7:1]==I2C_ADDR, go to ADDR_ACK, drive sda_t=0, busy=1; otherwise go to IGNORE with sda_t=1 (NACK).
  - ADDR_ACK: on the next SCL fall, release SDA. If R/W=0, go to PTR. If R/W=1, load shift register = regs[pointer], pointer++, drive the MSB, go to RDATA.
  - PTR: shift 8 bits. On the SCL fall after bit 8: pointer = byte mod NREG (low bits), sda_t=0, go to PTR_ACK.
  - PTR_ACK: on SCL fall, release SDA, go to WDATA.
  - WDATA: shift 8 bits. On the SCL fall after bit 8: regs[pointer]=byte, wr_stb=1 for one cycle with wr_idx=pointer, pointer++, sda_t=0, go to WDATA_ACK.
  - WDATA_ACK: on SCL fall, release SDA, go to WDATA. Unlimited bytes are accepted.
  - RDATA: on each SCL fall, drive the next bit (sda_t = bit value: 0 pulls low, 1 releases). After 8 bits, release SDA on the SCL fall, go to MACK.
  - MACK: sample SDA on SCL rise.
    - ACK (0): on SCL fall, load regs[pointer], pointer++, drive MSB, go to RDATA.
    - NACK (1): go to IGNORE.
  - IGNORE: sda_t=1; wait for START or STOP.
- Pointer arithmetic: $clog2(NREG) bits. Wraps NREG-1 -> 0 on both write and read.
- Simultaneous events:
  - START/STOP detection has priority over bit shifting in the same cycle.
  - A write commit and a repeated START in the same cycle cannot occur (they are on different SCL phases).
  - A partial byte interrupted by START or STOP is discarded: no register write, no wr_stb.
- Reset mid-transaction: sda_t goes to 1 asynchronously, so the bus is released immediately.
- Each SDA drive/release occurs at most 2 + FILT_LEN + 1 cycles after the physical SCL fall.

Test Plan:
1. Write: START, 0x84, 0x02, 0xA5, 0x3C, STOP -> four ACKs (sda_t=0 in each 9th slot); regs[2]=A5, regs[3]=3C; wr_stb pulses twice with wr_idx=2 then 3; busy falls after STOP.
2. Read with repeated START: START, 0x84, 0x02, Sr, 0x85, read two bytes (master ACK, then NACK), STOP -> bytes A5, 3C on SDA; no wr_stb; IGNORE reached after NACK.
3. Address mismatch: START, 0x90, 0x01, 0xFF, STOP -> sda_t stays 1 throughout; regs unchanged; busy stays 0.
4. Wrap: write pointer 7, data 0x11, 0x22 -> regs[7]=11, regs[0]=22. Pointer byte 0x0B with NREG=8 selects register 3.
5. Glitch and abort:
   - 2-cycle SDA low pulse while SCL high -> no START detected.
   - STOP after 5 bits of a data byte -> no register write, no wr_stb.
6. Reset mid-transaction: assert axi_aresetn during a WDATA_ACK slot -> sda_t=1 in the same cycle, regs all 0; a new START + 0x84 afterwards is ACKed normally.
